// File: rtl/rgb_fade_scaler.sv
// RGB brightness scaler: 2-stage pixel pipeline multiplying each channel by a
// per-pixel level snapshot, plus a fade engine that ramps the level toward a target.
module rgb_fade_scaler #(
   parameter int CW          = 8,
   parameter int LW          = 8,
   parameter int STEP_CYCLES = 4,
   parameter int STEP_SIZE   = 16,
   parameter int RESET_LEVEL = 2**LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [CW-1:0] r_in,
   input  logic [CW-1:0] g_in,
   input  logic [CW-1:0] b_in,
   output logic          out_valid,
   output logic [CW-1:0] r_out,
   output logic [CW-1:0] g_out,
   output logic [CW-1:0] b_out,
   input  logic          level_load,
   input  logic [LW:0]   level_value,
   input  logic          fade_start,
   input  logic [LW:0]   fade_target,
   output logic [LW:0]   level,
   output logic          busy,
   output logic          fade_done
);

   localparam logic [LW:0]   UNITY      = (LW+1)'(2**LW);
   localparam logic [LW:0]   RST_LVL    = (RESET_LEVEL > 2**LW) ? UNITY : (LW+1)'(RESET_LEVEL);
   localparam logic [LW+1:0] STEP_L     = (STEP_SIZE > 2**LW) ? (LW+2)'(2**LW) : (LW+2)'(STEP_SIZE);
   localparam int            CNT_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_CYCLES - 1);

   typedef enum logic {IDLE, FADING} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [LW:0]      target, target_nxt;
   logic [LW:0]      level_nxt;
   logic             done_nxt;

   logic             vld_p1;
   logic [CW-1:0]    r_p1, g_p1, b_p1;
   logic [LW:0]      lvl_p1;

   function automatic logic [LW:0] clamp_lvl(input logic [LW:0] v);
      return (v > UNITY) ? UNITY : v;
   endfunction

   // Distances are compared in LW+2 bits so a full-range step cannot wrap.
   function automatic logic [LW:0] step_toward(input logic [LW:0] cur, input logic [LW:0] tgt);
      logic [LW+1:0] c, t;
      c = {1'b0, cur};
      t = {1'b0, tgt};
      if (t > c)
         return ((t - c) <= STEP_L) ? tgt : cur + STEP_L[LW:0];
      else
         return ((c - t) <= STEP_L) ? tgt : cur - STEP_L[LW:0];
   endfunction

   function automatic logic [CW-1:0] scale(input logic [CW-1:0] ch, input logic [LW:0] lvl);
      logic [CW+LW:0] prod;
      prod = {{(LW+1){1'b0}}, ch} * {{CW{1'b0}}, lvl};
      return prod[CW+LW] ? {CW{1'b1}} : prod[CW+LW-1:LW];
   endfunction

   assign busy = (state == FADING);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      target_nxt = target;
      level_nxt  = level;
      done_nxt   = 1'b0;
      if (level_load) begin
         level_nxt = clamp_lvl(level_value);
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (fade_start) begin
         if (clamp_lvl(fade_target) == level) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
         end else begin
            target_nxt = clamp_lvl(fade_target);
            state_nxt  = FADING;
            cnt_nxt    = CNT_RELOAD;
         end
      end else if (state == FADING) begin
         if (cnt == '0) begin
            level_nxt = step_toward(level, target);
            cnt_nxt   = CNT_RELOAD;
            if (level_nxt == target) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end
         end else begin
            cnt_nxt = cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         target    <= RST_LVL;
         level     <= RST_LVL;
         fade_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         target    <= target_nxt;
         level     <= level_nxt;
         fade_done <= done_nxt;
      end
   end

   // Stage 1: capture pixel with the level in force on its input cycle
   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= in_valid;
      if (in_valid) begin
         r_p1   <= r_in;
         g_p1   <= g_in;
         b_p1   <= b_in;
         lvl_p1 <= level;
      end
   end

   // Stage 2: scale each channel; outputs hold while no pixel is present
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         r_out     <= '0;
         g_out     <= '0;
         b_out     <= '0;
      end else begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            r_out <= scale(r_p1, lvl_p1);
            g_out <= scale(g_p1, lvl_p1);
            b_out <= scale(b_p1, lvl_p1);
         end
      end
   end

endmodule

// File: tb/tb_rgb_fade_scaler.sv
// Directed bench for rgb_fade_scaler: pixel scaling, fades, retarget, load, reset.
module tb_rgb_fade_scaler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] r_in = '0, g_in = '0, b_in = '0;
   logic       out_valid;
   logic [7:0] r_out, g_out, b_out;
   logic       level_load = 1'b0;
   logic [8:0] level_value = '0;
   logic       fade_start = 1'b0;
   logic [8:0] fade_target = '0;
   logic [8:0] level;
   logic       busy;
   logic       fade_done;

   int n_tests = 0;
   int n_fail  = 0;

   rgb_fade_scaler #(.CW(8), .LW(8), .STEP_CYCLES(4), .STEP_SIZE(16), .RESET_LEVEL(256)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .out_valid(out_valid), .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .level_load(level_load), .level_value(level_value),
      .fade_start(fade_start), .fade_target(fade_target),
      .level(level), .busy(busy), .fade_done(fade_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rgb_now();
      return {8'h00, r_out, g_out, b_out};
   endfunction

   task automatic load_level(input logic [8:0] v);
      level_value = v;
      level_load  = 1'b1;
      tick;
      level_load  = 1'b0;
   endtask

   task automatic pix(input string tag, input logic [23:0] rgb, input logic [23:0] exp);
      {r_in, g_in, b_in} = rgb;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      chk({tag, "_vld1"}, 32'(out_valid), 32'd0);
      tick;
      chk({tag, "_vld2"}, 32'(out_valid), 32'd1);
      chk({tag, "_rgb"}, rgb_now(), {8'h00, exp});
   endtask

   // Drives the fade pulse, then checks level/busy/done each cycle against a step model.
   task automatic run_fade(input string tag, input logic [8:0] drive, input int start,
                           input int tgt, input int n);
      int e, prev;
      fade_target = drive;
      fade_start  = 1'b1;
      tick;
      fade_start  = 1'b0;
      chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      chk({tag, "_lvl_start"}, 32'(level), 32'(start));
      prev = start;
      for (int j = 1; j <= n; j++) begin
         tick;
         e = (j / 4) * 16;
         if (tgt > start) e = (start + e > tgt) ? tgt : start + e;
         else             e = (start - e < tgt) ? tgt : start - e;
         chk($sformatf("%s_lvl_%0d", tag, j), 32'(level), 32'(e));
         chk($sformatf("%s_busy_%0d", tag, j), 32'(busy), 32'(e != tgt));
         chk($sformatf("%s_done_%0d", tag, j), 32'(fade_done), 32'(e == tgt && prev != tgt));
         prev = e;
      end
   endtask

   logic [8:0]  lv_seq  [6] = '{9'd200, 9'd100, 9'd50, 9'd256, 9'd0, 9'd128};
   logic [23:0] exp_seq [6] = '{24'hC864FF, 24'h9C4EC7, 24'h4E2763, 24'h271331, 24'hC864FF, 24'h000000};

   initial begin
      tick;
      tick;
      chk("rst_level", 32'(level), 32'd256);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(fade_done), 32'd0);
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_rgb", rgb_now(), 32'h0);
      rst = 1'b0;
      tick;

      pix("unity_red", 24'hFF0000, 24'hFF0000);
      pix("unity_white", 24'hFFFFFF, 24'hFFFFFF);
      tick;
      chk("hold_rgb", rgb_now(), 32'h00FFFFFF);

      load_level(9'd128);
      chk("load128", 32'(level), 32'd128);
      pix("half_white", 24'hFFFFFF, 24'h7F7F7F);
      load_level(9'd64);
      pix("qtr_red", 24'hFF0000, 24'h3F0000);
      pix("qtr_cyan", 24'h007F7F, 24'h001F1F);
      load_level(9'd0);
      pix("zero_white", 24'hFFFFFF, 24'h000000);
      load_level(9'd300);
      chk("load_clamp", 32'(level), 32'd256);

      run_fade("dn128", 9'd128, 256, 128, 34);
      load_level(9'd0);
      run_fade("up250", 9'd250, 0, 250, 66);
      run_fade("clamp300", 9'd300, 250, 256, 6);

      fade_target = 9'd256;
      fade_start  = 1'b1;
      tick;
      fade_start  = 1'b0;
      chk("same_busy", 32'(busy), 32'd0);
      chk("same_done", 32'(fade_done), 32'd1);
      tick;
      chk("same_done_end", 32'(fade_done), 32'd0);

      run_fade("dn_to_0", 9'd0, 256, 0, 16);
      run_fade("retgt224", 9'd224, 192, 224, 10);
      run_fade("dn_again", 9'd0, 224, 0, 6);
      load_level(9'd10);
      chk("abort_lvl", 32'(level), 32'd10);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(fade_done), 32'd0);
      tick;
      chk("abort_lvl2", 32'(level), 32'd10);
      chk("abort_done2", 32'(fade_done), 32'd0);

      load_level(9'd256);
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) begin
            {r_in, g_in, b_in} = 24'hC864FF;
            in_valid    = 1'b1;
            level_value = lv_seq[i];
            level_load  = 1'b1;
         end else begin
            in_valid   = 1'b0;
            level_load = 1'b0;
         end
         tick;
         if (i >= 1) begin
            chk($sformatf("stream_vld_%0d", i - 1), 32'(out_valid), 32'd1);
            chk($sformatf("stream_rgb_%0d", i - 1), rgb_now(), {8'h00, exp_seq[i - 1]});
         end
      end
      level_load = 1'b0;

      {r_in, g_in, b_in} = 24'hFFFFFF;
      in_valid = 1'b1;
      tick;
      tick;
      chk("prerst_vld", 32'(out_valid), 32'd1);
      chk("prerst_rgb", rgb_now(), 32'h007F7F7F);
      fade_target = 9'd0;
      fade_start  = 1'b1;
      tick;
      fade_start  = 1'b0;
      chk("prerst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick;
      chk("midrst_vld", 32'(out_valid), 32'd0);
      chk("midrst_level", 32'(level), 32'd256);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rgb", rgb_now(), 32'h0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick;
      chk("postrst_vld", 32'(out_valid), 32'd0);
      chk("postrst_level", 32'(level), 32'd256);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
